// File: rtl/dds_synth_pkg.sv
// Shared types and constants for the polyphonic DDS sine synthesizer:
// sequencer states, the quarter-wave sine table, midscale and note increments.
package dds_synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PHASE  = 2'd1,
    LOOKUP = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam logic [7:0] MIDSCALE = 8'h80;

  // Phase increments per sample for a 50 MHz clock divided by 1024, 20-bit phase
  localparam logic [19:0] NOTE_INC_C5  = 20'd11237;
  localparam logic [19:0] NOTE_INC_CS5 = 20'd11905;
  localparam logic [19:0] NOTE_INC_D5  = 20'd12613;
  localparam logic [19:0] NOTE_INC_DS5 = 20'd13363;
  localparam logic [19:0] NOTE_INC_E5  = 20'd14157;
  localparam logic [19:0] NOTE_INC_F5  = 20'd14999;
  localparam logic [19:0] NOTE_INC_FS5 = 20'd15891;
  localparam logic [19:0] NOTE_INC_G5  = 20'd16836;
  localparam logic [19:0] NOTE_INC_GS5 = 20'd17837;
  localparam logic [19:0] NOTE_INC_A5  = 20'd18898;
  localparam logic [19:0] NOTE_INC_AS5 = 20'd20022;
  localparam logic [19:0] NOTE_INC_B5  = 20'd21212;
  localparam logic [19:0] NOTE_INC_C6  = 20'd22473;

  // round(127 * sin(pi/2 * i / 64)) for i = 0..63
  localparam logic [7:0] QSINE [64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
    8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
    8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
    8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
    8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127
  };

  function automatic logic [7:0] quarter_sine(input logic [5:0] idx);
    return QSINE[idx];
  endfunction

endpackage

// File: rtl/dds_quarter_sine_lut.sv
// Quarter-wave sine lookup with quadrant mirroring and negation; maps the
// top 2+LUT_ADDR_W phase bits to a signed sample.
module dds_quarter_sine_lut
  import dds_synth_pkg::*;
#(
  parameter int OUT_W      = 8,
  parameter int LUT_ADDR_W = 6
) (
  input  logic [LUT_ADDR_W+1:0]    phase_top,
  output logic signed [OUT_W-1:0]  value
);

  logic [1:0]              quad_s;
  logic [LUT_ADDR_W-1:0]   idx_s;
  logic signed [OUT_W-1:0] mag_s;

  // Odd quadrants run the table backwards, the lower half-wave is negated
  always_comb begin
    quad_s = phase_top[LUT_ADDR_W+1 -: 2];
    idx_s  = phase_top[LUT_ADDR_W-1:0];
    if (quad_s[0]) begin
      idx_s = ~idx_s;
    end else begin
      idx_s = phase_top[LUT_ADDR_W-1:0];
    end
    mag_s = signed'(OUT_W'(quarter_sine(idx_s)));
    if (quad_s[1]) begin
      value = -mag_s;
    end else begin
      value = mag_s;
    end
  end

endmodule

// File: rtl/dds_poly_sine_synth.sv
// Polyphonic DDS sine synthesizer: voices share one sine LUT in time slots and
// are mixed to one offset-binary sample. Optional envelope: DDS_SYNTH_ENVELOPE_EN.
module dds_poly_sine_synth
  import dds_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int OUT_W      = 8,
  parameter int PHASE_W    = 20,
  parameter int LUT_ADDR_W = 6,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_voice,
  input  logic [PHASE_W-1:0]    cfg_inc,
  input  logic                  cfg_gate,
  output logic [OUT_W-1:0]      sample_o,
  output logic                  sample_valid_o,
  output logic [NUM_VOICES-1:0] active_o
);

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int MIX_W = OUT_W + 4;
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  if (SAMPLE_DIV < 2*NUM_VOICES+2) begin : g_bad_div
    $error("SAMPLE_DIV must be at least 2*NUM_VOICES+2");
  end
  if ((NUM_VOICES < 1) || (NUM_VOICES > 16) || ((NUM_VOICES & (NUM_VOICES-1)) != 0)) begin : g_bad_nv
    $error("NUM_VOICES must be a power of 2 in 1..16");
  end
  if ((OUT_W != 8) || (LUT_ADDR_W != 6)) begin : g_bad_lut
    $error("sine table is built for OUT_W=8, LUT_ADDR_W=6");
  end

  state_t                  state_r, state_s;
  logic [DIV_W-1:0]        div_r;
  logic [VW-1:0]           v_r;
  logic signed [MIX_W-1:0] mix_r, mix_next_s, contrib_s;
  logic [OUT_W-1:0]        sample_r, out_val_s;
  logic                    valid_r, ready_r;
  logic [PHASE_W-1:0]      inc_r   [NUM_VOICES];
  logic [PHASE_W-1:0]      phase_r [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_r;
  logic                    tick_s, cfg_hit_s, advance_s;
  logic [VW-1:0]           cfg_sel_s;
  logic signed [OUT_W-1:0] lut_val_s;

  dds_quarter_sine_lut #(.OUT_W(OUT_W), .LUT_ADDR_W(LUT_ADDR_W)) u_lut (
    .phase_top (phase_r[v_r][PHASE_W-1 -: LUT_ADDR_W+2]),
    .value     (lut_val_s)
  );

  assign tick_s    = (div_r == DIV_W'(SAMPLE_DIV-1));
  assign cfg_hit_s = cfg_valid & ready_r & ({1'b0, cfg_voice} < 5'(NUM_VOICES));
  assign cfg_sel_s = cfg_voice[VW-1:0];

`ifdef DDS_SYNTH_ENVELOPE_EN
  logic [7:0]              env_r      [NUM_VOICES];
  logic [7:0]              env_step_s [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_r;
  logic signed [OUT_W+8:0] prod_s;

  // Linear attack/release step applied once per sample
  always_comb begin
    env_step_s = env_r;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_r[i]) begin
        env_step_s[i] = (env_r[i] == 8'd255) ? 8'd255 : env_r[i] + 8'd1;
      end else begin
        env_step_s[i] = (env_r[i] == 8'd0) ? 8'd0 : env_r[i] - 8'd1;
      end
    end
  end

  assign prod_s    = lut_val_s * signed'({1'b0, env_r[v_r]});
  assign contrib_s = MIX_W'(prod_s >>> 8);
  assign advance_s = gate_r[v_r] | (env_r[v_r] != 8'd0);
  assign active_o  = active_r;
`else
  assign contrib_s = gate_r[v_r] ? MIX_W'(lut_val_s) : '0;
  assign advance_s = gate_r[v_r];
  assign active_o  = gate_r;
`endif

  assign mix_next_s = mix_r + contrib_s;
  assign out_val_s  = OUT_W'(mix_next_s >>> SHIFT) + OUT_W'(MIDSCALE);

  // Sequencer next state: one PHASE/LOOKUP pair per voice, then OUT
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (tick_s) state_s = PHASE; else state_s = IDLE;
      PHASE:   state_s = LOOKUP;
      LOOKUP:  if (v_r == VW'(NUM_VOICES-1)) state_s = OUT; else state_s = PHASE;
      OUT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Divider, sequencer, mix accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r    <= '0;
      state_r  <= IDLE;
      v_r      <= '0;
      mix_r    <= '0;
      sample_r <= OUT_W'(MIDSCALE);
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      div_r   <= tick_s ? '0 : div_r + DIV_W'(1);
      state_r <= state_s;
      valid_r <= (state_s == OUT);
      ready_r <= (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            mix_r <= '0;
            v_r   <= '0;
          end
        end
        LOOKUP: begin
          mix_r <= mix_next_s;
          if (state_s == PHASE) v_r <= v_r + VW'(1);
        end
        default: ;
      endcase
      if (state_s == OUT) sample_r <= out_val_s;
    end
  end

  // Per-voice config, phase accumulators and (optionally) envelopes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc_r[i]   <= '0;
        phase_r[i] <= '0;
`ifdef DDS_SYNTH_ENVELOPE_EN
        env_r[i]   <= 8'd0;
`endif
      end
      gate_r <= '0;
`ifdef DDS_SYNTH_ENVELOPE_EN
      active_r <= '0;
`endif
    end else begin
      if (cfg_hit_s) begin
        inc_r[cfg_sel_s]  <= cfg_inc;
        gate_r[cfg_sel_s] <= cfg_gate;
      end
      if (state_r == PHASE) begin
        if (advance_s) phase_r[v_r] <= phase_r[v_r] + inc_r[v_r];
        else           phase_r[v_r] <= '0;
      end
`ifdef DDS_SYNTH_ENVELOPE_EN
      if (state_r == OUT) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          env_r[i]    <= env_step_s[i];
          active_r[i] <= (env_step_s[i] != 8'd0);
        end
      end
`endif
    end
  end

  assign cfg_ready      = ready_r;
  assign sample_o       = sample_r;
  assign sample_valid_o = valid_r;

endmodule

// File: tb/tb_dds_poly_sine_synth.sv
// Directed self-checking bench for dds_poly_sine_synth (4 voices, short
// sample divider); envelope checks run when DDS_SYNTH_ENVELOPE_EN is defined.
module tb_dds_poly_sine_synth;

  localparam int NV = 4;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_voice = 4'd0;
  logic [19:0] cfg_inc = 20'd0;
  logic        cfg_gate = 1'b0;
  logic [7:0]  sample_o;
  logic        sample_valid_o;
  logic [3:0]  active_o;

  int checks = 0;
  int failures = 0;

  dds_poly_sine_synth #(
    .NUM_VOICES(NV), .OUT_W(8), .PHASE_W(20), .LUT_ADDR_W(6), .SAMPLE_DIV(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice), .cfg_inc(cfg_inc), .cfg_gate(cfg_gate),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .active_o(active_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3*SD; i++) begin
      @(negedge clk);
      if (sample_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL sample_timeout observed=none expected=sample_valid_o");
    end
  endtask

  task automatic next_sample(input string tag, input logic [7:0] exp);
    logic ok;
    wait_valid(ok);
    if (ok) check(tag, sample_o, exp);
  endtask

  task automatic cfg_write(input logic [3:0] voice, input logic [19:0] inc, input logic gate);
    logic ok;
    ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_voice = voice;
    cfg_inc   = inc;
    cfg_gate  = gate;
    for (int i = 0; i < 4*SD && !ok; i++) begin
      if (cfg_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL cfg_timeout observed=no_ready expected=ready");
    end
  endtask

  task automatic measure_latency(input string tag, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 4*SD; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sample_valid_o === 1'b1) break;
    end
    check(tag, n, exp);
  endtask

  initial begin
    int n;
    logic ok;
    #2 rst_n = 1'b0;
    #2;
    check("rst_sample", sample_o, 8'h80);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_valid", sample_valid_o, 1'b0);
    check("rst_active", active_o, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure_latency("first_latency", SD + 2*NV);
    check("first_sample", sample_o, 8'h80);
    check("ready_in_out", cfg_ready, 1'b0);
    measure_latency("sample_period", SD);
    check("idle_sample", sample_o, 8'h80);

`ifdef DDS_SYNTH_ENVELOPE_EN
    cfg_write(4'd0, 20'h40000, 1'b1);
    for (int k = 1; k <= 257; k++) begin
      wait_valid(ok);
      if (!ok) break;
      if (k == 1)   check("env_k1", sample_o, 8'h80);
      if (k == 65)  check("env_k65", sample_o, 8'h87);
      if (k == 129) check("env_k129", sample_o, 8'h8F);
      if (k == 257) check("env_k257", sample_o, 8'h9F);
      if (k == 1) begin
        @(negedge clk);
        check("env_active_on", active_o, 4'b0001);
      end
    end
    cfg_write(4'd0, 20'h40000, 1'b0);
    n = 0;
    for (int j = 1; j <= 300; j++) begin
      wait_valid(ok);
      if (!ok) break;
      @(negedge clk);
      n = j;
      if (active_o[0] == 1'b0) break;
    end
    check("env_release_len", n, 255);
    next_sample("env_silent", 8'h80);
    check("env_active_off", active_o, 4'b0000);
`else
    cfg_write(4'd0, 20'h40000, 1'b1);
    next_sample("v0_s1", 8'h9F);
    next_sample("v0_s2", 8'h80);
    next_sample("v0_s3", 8'h60);
    next_sample("v0_s4", 8'h80);
    next_sample("v0_s5", 8'h9F);
    check("v0_active", active_o, 4'b0001);
    cfg_write(4'd0, 20'h40000, 1'b0);
    next_sample("v0_cleared", 8'h80);

    cfg_write(4'd0, 20'h40000, 1'b1);
    cfg_write(4'd1, 20'h40000, 1'b1);
    next_sample("v01_s1", 8'hBF);
    next_sample("v01_s2", 8'h80);
    next_sample("v01_s3", 8'h40);
    check("v01_active", active_o, 4'b0011);
    check("ready_low_busy", cfg_ready, 1'b0);
    cfg_write(4'd5, 20'h12345, 1'b1);
    next_sample("v5_discard", 8'h80);
    check("v5_active", active_o, 4'b0011);
    cfg_write(4'd0, 20'h00000, 1'b0);
    next_sample("v0_off_v1_on", 8'h9F);
    check("v1_only_active", active_o, 4'b0010);
    cfg_write(4'd1, 20'h00000, 1'b0);
    next_sample("all_off", 8'h80);

    cfg_write(4'd0, 20'h04000, 1'b1);
    next_sample("idx4", 8'h83);
    next_sample("idx8", 8'h86);
    cfg_write(4'd0, 20'h00000, 1'b0);
    next_sample("clear2", 8'h80);
    cfg_write(4'd0, 20'h84000, 1'b1);
    next_sample("neg_floor", 8'h7D);
    next_sample("wrap_idx8", 8'h86);
    cfg_write(4'd0, 20'h00000, 1'b0);
    next_sample("clear3", 8'h80);

    cfg_write(4'd0, 20'hFFFFF, 1'b1);
    next_sample("wrap_fffff", 8'h80);
    next_sample("wrap_ffffe", 8'h80);
    cfg_write(4'd0, 20'hC0000, 1'b1);
    next_sample("wrap_bfffe", 8'h60);
    next_sample("wrap_7fffe", 8'h80);
    next_sample("wrap_3fffe", 8'h9F);

    wait_valid(ok);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sample", sample_o, 8'h80);
    check("midrst_valid", sample_valid_o, 1'b0);
    check("midrst_active", active_o, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    measure_latency("midrst_latency", SD + 2*NV);
    check("midrst_first", sample_o, 8'h80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
